pu_mv_stream: RTL and testbench
===============================

// Module: pu_mv_stream
// PURPOSE
//  Streaming matrix-vector processing unit; successor to the fixed-length PU.
//  Each accepted beat carries one vector element A and MATRIX_ROW matrix elements B;
//  each lane accumulates A*B[i]. Column count is programmable per job.
//  Features: valid/ready input and output handshakes, optional per-lane saturation, error flag.
//  Sits between the operand fetch streams and the result writeback/FIFO.
// PARAMETERS
//  WIDTH_OP1   16  signed width of A
//  WIDTH_OP2   16  signed width of each B lane
//  WIDTH_OUT   32  signed accumulator/result width per lane (>= WIDTH_OP1+WIDTH_OP2)
//  MATRIX_ROW  8   lane count (matrix rows)
//  MAX_COL     16  maximum columns (beats) per job
//  COL_W       $clog2(MAX_COL+1)  width of NUM_COL
// PORTS
//  CLK        in   1                     clock, rising edge
//  RST        in   1                     async reset, active-high
//  START      in   1                     job request; sampled when accepted (see BEHAVIOUR)
//  NUM_COL    in   COL_W                 beats in this job, latched with START
//  SAT_EN     in   1                     1=saturate lanes, 0=two's-complement wrap; latched with START
//  IN_VALID   in   1                     A/B beat valid
//  IN_READY   out  1                     unit accepts beat
//  A          in   WIDTH_OP1             vector element (signed)
//  B          in   WIDTH_OP2*MATRIX_ROW  lane i at B[WIDTH_OP2*i +: WIDTH_OP2] (signed)
//  OUT_VALID  out  1                     OUT holds final result
//  OUT_READY  in   1                     consumer takes result
//  OUT        out  WIDTH_OUT*MATRIX_ROW  lane i at OUT[WIDTH_OUT*i +: WIDTH_OUT]
//  SAT_FLAG   out  MATRIX_ROW            sticky per-lane saturation/overflow indicator for the job
//  BUSY       out  1                     high in ACC or HOLD
//  DONE       out  1                     1-cycle pulse, first cycle of OUT_VALID
//  ERR        out  1                     1-cycle pulse: START rejected (NUM_COL==0 or >MAX_COL)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; accumulators, beat counter, SAT_FLAG cleared. Takes effect immediately, mid-job included; partial job discarded.
//  FSM IDLE -> ACC -> HOLD -> IDLE.
//   IDLE: IN_READY=0. START with 1<=NUM_COL<=MAX_COL -> clear accs, SAT_FLAG, cnt=0; latch NUM_COL, SAT_EN; go ACC.
//         START with illegal NUM_COL -> ERR pulse next cycle; stay IDLE.
//   ACC: IN_READY=1. Beat = IN_VALID&IN_READY. Per beat: acc[i] <= f(acc[i] + sext(A*B[i])); cnt++.
//        No beat -> hold all state. Beat with cnt==NUM_COL-1 -> go HOLD; IN_READY drops next cycle.
//   HOLD: OUT_VALID=1, OUT stable; DONE=1 on first HOLD cycle only. OUT_READY=1 -> go IDLE.
//         OUT_READY with START and legal NUM_COL, same cycle -> back-to-back: go ACC directly with accs cleared.
//         An illegal NUM_COL here -> ERR, go IDLE.
//  START in ACC, or in HOLD without OUT_READY: ignored, no ERR.
//  Latency: OUT_VALID/DONE rise the cycle after the last beat handshake.
//   Minimum job = NUM_COL+1 cycles from START acceptance to OUT_VALID.
//  Arithmetic: product signed, WIDTH_OP1+WIDTH_OP2 bits, sign-extended; sum computed at WIDTH_OUT+1 bits.
//   SAT_EN=1: overflow clamps to 2^(WIDTH_OUT-1)-1 or -2^(WIDTH_OUT-1), SAT_FLAG[i] set.
//   SAT_EN=0: wrap to WIDTH_OUT bits; SAT_FLAG[i] still set on overflow.
//   SAT_FLAG holds until next accepted START or RST.
//  OUT is driven directly from accumulators; valid only while OUT_VALID=1, otherwise don't-care to consumer.
// STRUCTURE
//  Shared package pu_pkg: FSM state encodings (IDLE/ACC/HOLD), sat/wrap add function, lane slice helper macros.
//  Sub-module pu_mac_lane (one signed MAC + saturation + sticky flag), instantiated MATRIX_ROW times by generate.
//  Top holds FSM, beat counter, latched NUM_COL/SAT_EN, handshake logic.
// TESTING
//  1 Default params, NUM_COL=16, IN_VALID always 1, random A,B in [-31,31] -> OUT matches golden sum; DONE 17 cycles after START.
//  2 NUM_COL=3, IN_VALID toggled 1,0,0,1,0,1 -> exactly 3 beats summed; OUT_VALID held until OUT_READY; OUT stable while stalled.
//  3 SAT_EN=1, A=B=32767 all lanes, NUM_COL=16 -> OUT=32'h7FFFFFFF per lane and SAT_FLAG=8'hFF. SAT_EN=0 same stimulus -> OUT wraps and SAT_FLAG=8'hFF.
//  4 START with NUM_COL=0 and with NUM_COL=17 -> ERR pulse, BUSY stays 0; START during ACC -> ignored, no ERR.
//  5 Back-to-back: OUT_READY=1 and START (NUM_COL=2) in the same HOLD cycle -> next cycle ACC with cleared accs; second result independent of first.
//  6 RST asserted mid-ACC after 5 beats -> all outputs 0 asynchronously; new job after release gives a correct result.

Source files
------------

// File: rtl/pu_pkg.sv
// Shared types and arithmetic for the streaming matrix-vector PU.
// sat_add works at a fixed 64-bit container; callers pass their real width (<= 63 bits).
package pu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic signed [63:0] val;
    logic               ovf;
  } add_res_t;

  // Adds at 65 bits, then clamps or wraps into a signed field of w bits.
  function automatic add_res_t sat_add(input logic signed [63:0] acc,
                                       input logic signed [63:0] addend,
                                       input int                 w,
                                       input logic               sat);
    logic signed [64:0] s;
    logic signed [64:0] maxv;
    logic signed [64:0] minv;
    logic signed [64:0] wrapped;
    add_res_t           r;
    s       = {acc[63], acc} + {addend[63], addend};
    maxv    = (65'sd1 <<< (w - 1)) - 65'sd1;
    minv    = -maxv - 65'sd1;
    wrapped = (s <<< (65 - w)) >>> (65 - w);
    r.ovf   = (s > maxv) || (s < minv);
    if (sat && (s > maxv))
      r.val = maxv[63:0];
    else if (sat && (s < minv))
      r.val = minv[63:0];
    else
      r.val = wrapped[63:0];
    return r;
  endfunction

endpackage

// File: rtl/pu_mac_lane.sv
// One signed MAC lane: acc <= sat/wrap(acc + a*b) on en, sticky overflow flag.
// clr has priority over en so a back-to-back job starts from zero.
module pu_mac_lane
  import pu_pkg::*;
#(
  parameter int W1 = 16,
  parameter int W2 = 16,
  parameter int WO = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 sat_en,
  input  logic signed [W1-1:0] a,
  input  logic signed [W2-1:0] b,
  output logic        [WO-1:0] acc,
  output logic                 flag
);

  localparam int PW = W1 + W2;

  logic signed [PW-1:0] prod;
  logic signed [63:0]   acc64;
  logic signed [63:0]   add64;
  add_res_t             res;

  always_comb begin
    prod  = PW'(a) * PW'(b);
    acc64 = {{(64 - WO){acc[WO-1]}}, acc};
    add64 = {{(64 - PW){prod[PW-1]}}, prod};
    res   = sat_add(acc64, add64, WO, sat_en);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc  <= '0;
      flag <= 1'b0;
    end else if (clr) begin
      acc  <= '0;
      flag <= 1'b0;
    end else if (en) begin
      acc  <= res.val[WO-1:0];
      flag <= flag | res.ovf;
    end
  end

endmodule

// File: rtl/pu_mv_stream.sv
// Streaming matrix-vector PU: per beat, every lane accumulates A*B[i] over NUM_COL beats.
// Result held in HOLD until OUT_READY; a legal START in that same cycle chains the next job.
module pu_mv_stream
  import pu_pkg::*;
#(
  parameter int WIDTH_OP1  = 16,
  parameter int WIDTH_OP2  = 16,
  parameter int WIDTH_OUT  = 32,
  parameter int MATRIX_ROW = 8,
  parameter int MAX_COL    = 16,
  parameter int COL_W      = $clog2(MAX_COL + 1)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            START,
  input  logic [COL_W-1:0]                NUM_COL,
  input  logic                            SAT_EN,
  input  logic                            IN_VALID,
  output logic                            IN_READY,
  input  logic [WIDTH_OP1-1:0]            A,
  input  logic [WIDTH_OP2*MATRIX_ROW-1:0] B,
  output logic                            OUT_VALID,
  input  logic                            OUT_READY,
  output logic [WIDTH_OUT*MATRIX_ROW-1:0] OUT,
  output logic [MATRIX_ROW-1:0]           SAT_FLAG,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            ERR
);

  state_t           state;
  state_t           state_nxt;
  logic [COL_W-1:0] cnt;
  logic [COL_W-1:0] num_col_q;
  logic             sat_en_q;
  logic             done_q;
  logic             err_q;

  logic col_ok;
  logic start_win;
  logic accept;
  logic reject;
  logic beat;
  logic last;

  // START is only looked at when the unit can actually take a new job.
  assign col_ok    = (NUM_COL != '0) && (NUM_COL <= COL_W'(MAX_COL));
  assign start_win = (state == ST_IDLE) || ((state == ST_HOLD) && OUT_READY);
  assign accept    = START && col_ok && start_win;
  assign reject    = START && !col_ok && start_win;
  assign beat      = IN_VALID && IN_READY;
  assign last      = beat && (cnt == (num_col_q - 1'b1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_ACC;
      ST_ACC:  if (last)   state_nxt = ST_HOLD;
      ST_HOLD: if (OUT_READY) state_nxt = accept ? ST_ACC : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (state == ST_ACC);
    OUT_VALID = (state == ST_HOLD);
    BUSY      = (state != ST_IDLE);
  end

  assign DONE = done_q;
  assign ERR  = err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt       <= '0;
      num_col_q <= '0;
      sat_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= last;
      err_q  <= reject;
      if (accept) begin
        cnt       <= '0;
        num_col_q <= NUM_COL;
        sat_en_q  <= SAT_EN;
      end else if (beat) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < MATRIX_ROW; i++) begin : g_lane
    pu_mac_lane #(
      .W1(WIDTH_OP1),
      .W2(WIDTH_OP2),
      .WO(WIDTH_OUT)
    ) u_lane (
      .clk   (CLK),
      .rst   (RST),
      .clr   (accept),
      .en    (beat),
      .sat_en(sat_en_q),
      .a     (A),
      .b     (B[WIDTH_OP2*i +: WIDTH_OP2]),
      .acc   (OUT[WIDTH_OUT*i +: WIDTH_OUT]),
      .flag  (SAT_FLAG[i])
    );
  end

endmodule

// File: tb/tb_pu_mv_stream.sv
// Directed bench for pu_mv_stream: a transaction-level model tracks phase and lane sums,
// a negedge compare process checks handshakes/results, literal checks pin the model.
module tb_pu_mv_stream;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [4:0]   num_col;
  logic         sat_en;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  a;
  logic [127:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [255:0] out;
  logic [7:0]   sat_flag;
  logic         busy;
  logic         done;
  logic         err;

  pu_mv_stream dut (
    .CLK(clk), .RST(rst), .START(start), .NUM_COL(num_col), .SAT_EN(sat_en),
    .IN_VALID(in_valid), .IN_READY(in_ready), .A(a), .B(b),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT(out),
    .SAT_FLAG(sat_flag), .BUSY(busy), .DONE(done), .ERR(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 accumulating, 2 holding result.
  int     exp_phase = 0;
  bit     exp_done = 0;
  bit     exp_err = 0;
  int     m_n = 0;
  int     m_cnt = 0;
  bit     m_sat = 0;
  longint m_acc[8];
  logic [7:0] m_flag = '0;
  bit     chk_en = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < 8; i++) m_acc[i] = 0;
    m_flag = '0;
    m_cnt  = 0;
  endfunction

  function automatic void model_beat(input logic [15:0] av, input logic [127:0] bv);
    longint     p, s;
    logic [15:0] bl;
    for (int i = 0; i < 8; i++) begin
      bl = bv[16*i +: 16];
      p  = longint'($signed(av)) * longint'($signed(bl));
      s  = m_acc[i] + p;
      if (s > 64'sd2147483647 || s < -64'sd2147483648) begin
        m_flag[i] = 1'b1;
        if (m_sat) s = (s > 0) ? 64'sd2147483647 : -64'sd2147483648;
        else       s = longint'(int'(s));
      end
      m_acc[i] = s;
    end
  endfunction

  function automatic logic [255:0] model_out();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = m_acc[i][31:0];
    return r;
  endfunction

  function automatic bit legal(input logic [4:0] n);
    return (n >= 1) && (n <= 16);
  endfunction

  // One clock: update the model from the inputs the bench drove into this edge.
  task automatic step();
    @(posedge clk);
    exp_done = 0;
    exp_err  = 0;
    if (rst) begin
      exp_phase = 0;
      model_clear();
    end else begin
      case (exp_phase)
        0: if (start) begin
             if (legal(num_col)) begin
               model_clear(); m_n = int'(num_col); m_sat = sat_en; exp_phase = 1;
             end else exp_err = 1;
           end
        1: if (in_valid) begin
             model_beat(a, b);
             m_cnt++;
             if (m_cnt == m_n) begin exp_phase = 2; exp_done = 1; end
           end
        default: if (out_ready) begin
             if (start && legal(num_col)) begin
               model_clear(); m_n = int'(num_col); m_sat = sat_en; exp_phase = 1;
             end else begin
               exp_err   = start;
               exp_phase = 0;
             end
           end
      endcase
    end
    #1;
  endtask

  task automatic start_job(input int n, input bit sat);
    start = 1'b1; num_col = 5'(n); sat_en = sat;
    step();
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] av, input logic [127:0] bv, input bit v);
    in_valid = v; a = av; b = bv;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int stall);
    out_ready = 1'b0;
    repeat (stall) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("in_ready",  256'(in_ready),  256'(exp_phase == 1));
      check("out_valid", 256'(out_valid), 256'(exp_phase == 2));
      check("busy",      256'(busy),      256'(exp_phase != 0));
      check("done",      256'(done),      256'(exp_done));
      check("err",       256'(err),       256'(exp_err));
      if (exp_phase == 2) begin
        check("out",      out,             model_out());
        check("sat_flag", 256'(sat_flag),  256'(m_flag));
      end
    end
  end

  initial begin
    logic [255:0] exp_v;
    logic [127:0] rb;
    int cyc, done_at;

    rst = 1'b1; start = 0; num_col = 0; sat_en = 0; in_valid = 0;
    a = '0; b = '0; out_ready = 0;
    model_clear();
    step(); step();
    check("rst_out",      out,                 256'd0);
    check("rst_flags",    256'(sat_flag),      256'd0);
    check("rst_ctl",      256'({in_ready, out_valid, busy, done, err}), 256'd0);
    rst = 1'b0;
    chk_en = 1;
    step();

    // 1: full-length job, random small operands, DONE latency
    start_job(16, 0);
    cyc = 1; done_at = 0;
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 8; i++) rb[16*i +: 16] = 16'($urandom_range(62)) - 16'd31;
      feed(16'($urandom_range(62)) - 16'd31, rb, 1'b1);
      cyc++;
      if (done && done_at == 0) done_at = cyc;
    end
    check("done_latency", 256'(done_at), 256'd17);
    drain(1);

    // 2: stalled input stream, held output
    start_job(3, 0);
    for (int i = 0; i < 8; i++) rb[16*i +: 16] = 16'(i + 1);
    feed(16'd2, rb, 1'b1);
    feed(16'd99, {8{16'd55}}, 1'b0);
    feed(16'd99, {8{16'd55}}, 1'b0);
    feed(-16'sd3, {8{16'd4}}, 1'b1);
    feed(16'd77, {8{16'd9}}, 1'b0);
    for (int i = 0; i < 8; i++) rb[16*i +: 16] = 16'(-i);
    feed(16'd5, rb, 1'b1);
    for (int i = 0; i < 8; i++) exp_v[32*i +: 32] = 32'(-3 * i - 10);
    check("stall_sum", out, exp_v);
    drain(3);

    // 3: saturate then wrap on the same extreme stimulus
    start_job(16, 1);
    repeat (16) feed(16'h7FFF, {8{16'h7FFF}}, 1'b1);
    check("sat_out",  out,            {8{32'h7FFFFFFF}});
    check("sat_flag", 256'(sat_flag), 256'hFF);
    drain(0);
    start_job(16, 0);
    repeat (16) feed(16'h7FFF, {8{16'h7FFF}}, 1'b1);
    check("wrap_out",  out,            {8{32'hFFF00010}});
    check("wrap_flag", 256'(sat_flag), 256'hFF);
    drain(0);

    // 4: illegal column counts, START ignored while accumulating
    start = 1; num_col = 5'd0; step(); start = 0;
    check("err_zero", 256'({err, busy}), 256'b10);
    step();
    start = 1; num_col = 5'd17; step(); start = 0;
    check("err_17", 256'({err, busy}), 256'b10);
    step();
    check("err_pulse", 256'(err), 256'd0);
    start_job(2, 0);
    start = 1; num_col = 5'd0;
    feed(16'd1, {8{16'd3}}, 1'b1);
    start = 0;
    check("acc_start_ignored", 256'({err, in_ready}), 256'b01);
    feed(16'd2, {8{16'd3}}, 1'b1);
    drain(0);

    // 5: back-to-back jobs, then an illegal chained START
    start_job(2, 0);
    feed(16'd1, {8{16'd100}}, 1'b1);
    feed(16'd1, {8{16'd100}}, 1'b1);
    check("b2b_first", out, {8{32'd200}});
    out_ready = 1; start = 1; num_col = 5'd2; sat_en = 0;
    step();
    out_ready = 0; start = 0;
    check("b2b_cleared", 256'({in_ready, out_valid}) , 256'b10);
    check("b2b_acc_zero", out, 256'd0);
    feed(16'd1, {8{16'd7}}, 1'b1);
    feed(16'd1, {8{16'd7}}, 1'b1);
    check("b2b_second", out, {8{32'd14}});
    out_ready = 1; start = 1; num_col = 5'd0;
    step();
    out_ready = 0; start = 0;
    check("hold_err", 256'({err, busy}), 256'b10);
    step();

    // 6: asynchronous reset mid-job, then a clean job
    start_job(8, 0);
    repeat (5) feed(16'd9, {8{16'd9}}, 1'b1);
    #2 rst = 1'b1;
    exp_phase = 0;
    model_clear();
    #1;
    check("arst_out",   out,            256'd0);
    check("arst_flags", 256'(sat_flag), 256'd0);
    check("arst_ctl",   256'({in_ready, out_valid, busy, done, err}), 256'd0);
    step();
    rst = 1'b0;
    step();
    start_job(1, 0);
    feed(16'd3, {8{-16'sd4}}, 1'b1);
    check("post_rst", out, {8{32'hFFFFFFF4}});
    drain(0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
